bounce_sprite: RTL and testbench

BOUNCE_SPRITE -- requirements
Module: bounce_sprite

---
 rtl/bounce_sprite.sv | 147 ++++++++++++++
 tb/tb_bounce_sprite.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bounce_sprite.sv
// Bouncing square sprite overlay for a VGA pixel stream. Motion and wall
// bounces update once per frame, and the pixel path is registered with one cycle of latency.
module bounce_sprite #(
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter int         SPR_W    = 32,
    parameter int         SPR_H    = 32,
    parameter int         SPEED    = 2,
    parameter logic [7:0] BG_COLOR = 8'h03
) (
    input  logic       vgaclk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       pause,
    output logic [7:0] color,
    output logic       de,
    output logic [7:0] bounce_cnt,
    output logic       corner_hit
);
    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPR_W);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPR_H);
    localparam logic [10:0] STEP  = 11'(SPEED);

    logic [9:0] r_x, r_y;
    logic       r_dx, r_dy;
    logic [1:0] r_pal;
    logic [7:0] r_bounce_cnt;
    logic       r_corner;
    logic [7:0] r_color;
    logic       r_de;

    logic        w_frame_tick;
    logic        w_move;
    logic [10:0] w_x_sum, w_y_sum;
    logic [9:0]  w_x_nxt, w_y_nxt;
    logic        w_dx_nxt, w_dy_nxt;
    logic        w_xb, w_yb;
    logic        w_active, w_in_spr;
    logic [7:0]  w_spr_color;

    assign w_frame_tick = (hc == 10'd0) && (vc == 10'(V_ACTIVE));
    assign w_move       = w_frame_tick && !pause;

    // 11-bit sums so a step past the far wall clamps instead of wrapping
    assign w_x_sum = {1'b0, r_x} + STEP;
    assign w_y_sum = {1'b0, r_y} + STEP;

    always_comb begin
        w_x_nxt  = r_x;
        w_dx_nxt = r_dx;
        w_xb     = 1'b0;
        if (r_dx) begin
            if (w_x_sum >= X_MAX) begin
                w_x_nxt  = X_MAX[9:0];
                w_dx_nxt = 1'b0;
                w_xb     = 1'b1;
            end else begin
                w_x_nxt = w_x_sum[9:0];
            end
        end else begin
            if ({1'b0, r_x} <= STEP) begin
                w_x_nxt  = 10'd0;
                w_dx_nxt = 1'b1;
                w_xb     = 1'b1;
            end else begin
                w_x_nxt = r_x - STEP[9:0];
            end
        end
    end

    always_comb begin
        w_y_nxt  = r_y;
        w_dy_nxt = r_dy;
        w_yb     = 1'b0;
        if (r_dy) begin
            if (w_y_sum >= Y_MAX) begin
                w_y_nxt  = Y_MAX[9:0];
                w_dy_nxt = 1'b0;
                w_yb     = 1'b1;
            end else begin
                w_y_nxt = w_y_sum[9:0];
            end
        end else begin
            if ({1'b0, r_y} <= STEP) begin
                w_y_nxt  = 10'd0;
                w_dy_nxt = 1'b1;
                w_yb     = 1'b1;
            end else begin
                w_y_nxt = r_y - STEP[9:0];
            end
        end
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_dx         <= 1'b1;
            r_dy         <= 1'b1;
            r_pal        <= '0;
            r_bounce_cnt <= '0;
            r_corner     <= 1'b0;
        end else begin
            r_corner <= w_move && w_xb && w_yb;
            if (w_move) begin
                r_x  <= w_x_nxt;
                r_y  <= w_y_nxt;
                r_dx <= w_dx_nxt;
                r_dy <= w_dy_nxt;
                if (w_xb || w_yb) begin
                    r_bounce_cnt <= r_bounce_cnt + 8'd1;
                    r_pal        <= r_pal + 2'd1;
                end
            end
        end
    end

    // Compare in 11 bits so out-of-range counts (up to 1023) fall cleanly into blanking
    assign w_active = ({1'b0, hc} < 11'(H_ACTIVE)) && ({1'b0, vc} < 11'(V_ACTIVE));
    assign w_in_spr = (hc >= r_x) && ({1'b0, hc} < {1'b0, r_x} + 11'(SPR_W)) &&
                      (vc >= r_y) && ({1'b0, vc} < {1'b0, r_y} + 11'(SPR_H));

    always_comb begin
        case (r_pal)
            2'd0:    w_spr_color = 8'hE0;
            2'd1:    w_spr_color = 8'h1C;
            2'd2:    w_spr_color = 8'hFC;
            default: w_spr_color = 8'hFF;
        endcase
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_color <= 8'h00;
            r_de    <= 1'b0;
        end else begin
            r_de    <= w_active;
            r_color <= !w_active ? 8'h00 : (w_in_spr ? w_spr_color : BG_COLOR);
        end
    end

    assign color      = r_color;
    assign de         = r_de;
    assign bounce_cnt = r_bounce_cnt;
    assign corner_hit = r_corner;
endmodule

// File: tb/tb_bounce_sprite.sv
// Randomized bench for bounce_sprite against a frame-level model of the sprite's motion.
module tb_bounce_sprite;
    logic       vgaclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hc = '0, vc = '0;
    logic       pause = 1'b0;
    logic [7:0] color, bounce_cnt;
    logic       de, corner_hit;

    int n_chk = 0, n_err = 0, n_corner = 0;

    // reference model state
    int mx, my, mcnt, mpal;
    bit mdx, mdy, mcorner;

    bounce_sprite dut (
        .vgaclk(vgaclk), .rst(rst), .hc(hc), .vc(vc), .pause(pause),
        .color(color), .de(de), .bounce_cnt(bounce_cnt), .corner_hit(corner_hit)
    );

    always #20 vgaclk = ~vgaclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pal_color(int p);
        int t[4] = '{'hE0, 'h1C, 'hFC, 'hFF};
        return t[p];
    endfunction

    function automatic int exp_color(int h, int v);
        if (h >= 640 || v >= 480) return 0;
        if (h >= mx && h < mx + 32 && v >= my && v < my + 32) return pal_color(mpal);
        return 'h03;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcnt = 0; mpal = 0; mcorner = 0;
    endtask

    // One frame of motion on an axis: move by 2 within [0,lim], reversing at the walls
    task automatic axis(inout int p, inout bit d, input int lim, output bit b);
        b = 0;
        if (d) begin
            if (p + 2 >= lim) begin p = lim; d = 0; b = 1; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; d = 1; b = 1; end
            else p = p - 2;
        end
    endtask

    task automatic model_tick(input bit p);
        bit bx, by;
        mcorner = 0;
        if (p) return;
        axis(mx, mdx, 608, bx);
        axis(my, mdy, 448, by);
        if (bx || by) begin
            mcnt = (mcnt + 1) % 256;
            mpal = (mpal + 1) % 4;
        end
        mcorner = bx && by;
    endtask

    task automatic step(input int h, input int v, input bit p, input bit r);
        int ecol, ede;
        hc = 10'(h); vc = 10'(v); pause = p; rst = r;
        if (r) begin
            model_reset();
            ecol = 0; ede = 0;
        end else begin
            ecol = exp_color(h, v);
            ede  = (h < 640 && v < 480) ? 1 : 0;
            if (h == 0 && v == 480) model_tick(p);
            else mcorner = 0;
        end
        @(posedge vgaclk);
        #1;
        chk("color", color, ecol);
        chk("de", de, ede);
        chk("bounce_cnt", bounce_cnt, mcnt);
        chk("corner_hit", corner_hit, mcorner);
        if (corner_hit === 1'b1) n_corner++;
    endtask

    task automatic probe();
        if ($urandom_range(0, 3) == 0)
            step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b0);
        else
            step(mx + $urandom_range(0, 34), my + $urandom_range(0, 34), 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // reset held two cycles, then a sprite pixel at (5,5)
        step(5, 5, 0, 1);
        step(5, 5, 0, 1);
        step(5, 5, 0, 0);
        chk("rst_color", color, 8'hE0);
        // three frames of motion
        repeat (3) step(0, 480, 0, 0);
        step(6, 6, 0, 0);
        chk("pix_6_6", color, 8'hE0);
        step(5, 6, 0, 0);
        chk("pix_5_6", color, 8'h03);
        // pause holds everything
        repeat (5) step(0, 480, 1, 0);
        step(6, 6, 0, 0);
        chk("pause_hold", color, 8'hE0);
        step(700, 5, 0, 0);
        chk("blank_de", de, 1'b0);
        step(1023, 1023, 0, 0);
        // long unpaused run: right-wall bounce at tick 304, then a corner near 4256
        for (int i = 0; i < 4300; i++) begin
            step(0, 480, 0, 0);
            probe();
        end
        chk("corner_seen", (n_corner > 0) ? 32'd1 : 32'd0, 32'd1);
        // random mix of paused/unpaused ticks, probes and resets (including reset on a tick)
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: step(0, 480, ($urandom_range(0, 3) == 0), 0);
                3:       step(0, 480, $urandom_range(0, 1), ($urandom_range(0, 40) == 0));
                default: probe();
            endcase
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
